sw_mode_decoder: RTL and testbench

Input-side front end for the LED pattern FSM: samples the four raw board switches, synchronises and debounces them as one vector, and delivers a clean, glitch-free 4-bit mode code plus validity/change indications. It sits between the board pins and the pattern FSM's switch input. The FSM only ever sees committed, stable values.

---
 rtl/fsm_pkg.sv | 28 ++
 rtl/sync_ff.sv | 30 +++
 rtl/sw_mode_decoder.sv | 114 +++++++++++
 tb/tb_sw_mode_decoder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// Shared definitions for the LED pattern front end and pattern FSM:
// mode codes, debounce state encoding and a popcount helper.
package fsm_pkg;

    // Pattern mode codes, one-hot; the pattern FSM uses the same constants.
    localparam logic [3:0] MODE_IDLE        = 4'b0000;
    localparam logic [3:0] MODE_BLINK_TWICE = 4'b0001;
    localparam logic [3:0] MODE_BLINK       = 4'b0010;
    localparam logic [3:0] MODE_ALTERNATE   = 4'b0100;
    localparam logic [3:0] MODE_SHIFT       = 4'b1000;

    // Debounce FSM states.
    typedef enum logic [0:0] {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } dbnc_state_e;

    // Number of set bits in a 4-bit switch vector.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchroniser for an asynchronous input vector.
module sync_ff #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the raw vector through the synchroniser chain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_q[0] <= d_i;
            for (int k = 1; k < STAGES; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/sw_mode_decoder.sv
// Switch front end: synchronises the four board switches, debounces them as
// one vector and presents a committed mode code with valid/error/change flags.
module sw_mode_decoder
    import fsm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_sw_raw,
    output logic [3:0] o_sw,
    output logic       o_mode_valid,
    output logic       o_error,
    output logic       o_change
);

    localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync_s;
    dbnc_state_e      state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       sw_q, sw_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             chg_q, chg_d;
    logic [2:0]       cand_ones_s;

    sync_ff #(
        .WIDTH  (4),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (i_clk),
        .rst_i (i_rst),
        .d_i   (i_sw_raw),
        .q_o   (sync_s)
    );

    assign cand_ones_s = popcount4(cand_q);

    // Debounce next-state: track a candidate, count its hold time, commit when stable.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        sw_d    = sw_q;
        valid_d = valid_q;
        err_d   = err_q;
        chg_d   = 1'b0;
        case (state_q)
            STABLE: begin
                if (sync_s != sw_q) begin
                    state_d = SETTLING;
                    cand_d  = sync_s;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = STABLE;
                end
            end
            SETTLING: begin
                if (sync_s == sw_q) begin
                    // Bounced back to the committed value: abandon the candidate.
                    state_d = STABLE;
                end else if (sync_s != cand_q) begin
                    // Bounced to a third value: restart the hold time.
                    cand_d = sync_s;
                    cnt_d  = {CNT_W{1'b0}};
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE;
                    sw_d    = cand_q;
                    valid_d = (cand_ones_s == 3'd1);
                    err_d   = (cand_ones_s >= 3'd2);
                    chg_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cand_d  = 4'b0000;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, candidate, counter and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= STABLE;
            cand_q  <= 4'b0000;
            cnt_q   <= {CNT_W{1'b0}};
            sw_q    <= MODE_IDLE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            chg_q   <= chg_d;
        end
    end

    assign o_sw         = sw_q;
    assign o_mode_valid = valid_q;
    assign o_error      = err_q;
    assign o_change     = chg_q;

endmodule

// File: tb/tb_sw_mode_decoder.sv
// Self-checking bench for sw_mode_decoder: vector table, hand-written corner
// sequences and a randomized run against a run-length reference model.
module tb_sw_mode_decoder;

    localparam int D = 4;
    localparam int S = 2;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [3:0] i_sw_raw = 4'b0000;
    logic [3:0] o_sw;
    logic       o_mode_valid;
    logic       o_error;
    logic       o_change;

    always #5 i_clk = ~i_clk;

    sw_mode_decoder #(
        .DEBOUNCE_CYCLES (D),
        .SYNC_STAGES     (S)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_sw_raw     (i_sw_raw),
        .o_sw         (o_sw),
        .o_mode_valid (o_mode_valid),
        .o_error      (o_error),
        .o_change     (o_change)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc_no = 0;
    int pulses[$];

    // Reference model: raw samples delayed S edges, committed once the same
    // non-committed value has been seen on D+1 consecutive edges.
    logic [3:0] m_pipe [S];
    logic [3:0] m_sw    = 4'b0000;
    logic [3:0] m_cand  = 4'b0000;
    logic       m_valid = 1'b0;
    logic       m_err   = 1'b0;
    logic       m_chg   = 1'b0;
    int         m_run   = 0;

    typedef struct {
        logic       rst;
        logic [3:0] sw;
        logic [3:0] e_sw;
        logic       e_v;
        logic       e_e;
        logic       e_c;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %b, want %b", name, cyc_no, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, want %0d", name, cyc_no, act, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic [3:0] sw);
        logic [3:0] s;
        if (rst) begin
            for (int k = 0; k < S; k++) m_pipe[k] = 4'b0000;
            m_sw = 4'b0000; m_cand = 4'b0000;
            m_valid = 1'b0; m_err = 1'b0; m_chg = 1'b0; m_run = 0;
        end else begin
            s = m_pipe[S-1];
            for (int k = S - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
            m_pipe[0] = sw;
            m_chg = 1'b0;
            if (s == m_sw) begin
                m_run = 0;
            end else if (m_run > 0 && s == m_cand) begin
                m_run++;
            end else begin
                m_cand = s;
                m_run  = 1;
            end
            if (m_run == D + 1) begin
                m_sw    = m_cand;
                m_valid = ($countones(m_cand) == 1);
                m_err   = ($countones(m_cand) >= 2);
                m_chg   = 1'b1;
                m_run   = 0;
            end
        end
    endtask

    // One clock: drive, let the edge happen, update model, compare at negedge.
    task automatic cyc(input logic rst, input logic [3:0] sw);
        i_rst    = rst;
        i_sw_raw = sw;
        @(posedge i_clk);
        model_edge(rst, sw);
        cyc_no++;
        @(negedge i_clk);
        chk("model_sw",    o_sw, m_sw);
        chk("model_valid", {3'b000, o_mode_valid}, {3'b000, m_valid});
        chk("model_error", {3'b000, o_error},      {3'b000, m_err});
        chk("model_chg",   {3'b000, o_change},     {3'b000, m_chg});
        if (o_change === 1'b1) pulses.push_back(cyc_no);
    endtask

    task automatic add(input logic rst, input logic [3:0] sw, input logic [3:0] e_sw,
                       input logic e_v, input logic e_e, input logic e_c);
        vec_t v;
        v.rst = rst; v.sw = sw; v.e_sw = e_sw; v.e_v = e_v; v.e_e = e_e; v.e_c = e_c;
        tbl.push_back(v);
    endtask

    initial begin
        for (int k = 0; k < S; k++) m_pipe[k] = 4'b0000;

        // Clean step to 0010, then multi-hot 0011, then back to idle.
        add(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) add(1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b1);
        add(1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) add(1'b0, 4'b0011, 4'b0010, 1'b1, 1'b0, 1'b0);
        add(1'b0, 4'b0011, 4'b0011, 1'b0, 1'b1, 1'b1);
        add(1'b0, 4'b0011, 4'b0011, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) add(1'b0, 4'b0000, 4'b0011, 1'b0, 1'b1, 1'b0);
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst, tbl[i].sw);
            chk("tbl_sw",    o_sw, tbl[i].e_sw);
            chk("tbl_valid", {3'b000, o_mode_valid}, {3'b000, tbl[i].e_v});
            chk("tbl_error", {3'b000, o_error},      {3'b000, tbl[i].e_e});
            chk("tbl_chg",   {3'b000, o_change},     {3'b000, tbl[i].e_c});
        end

        // Bounce rejection: 3-cycle high never commits.
        cyc(1'b1, 4'b0000);
        pulses.delete();
        for (int i = 0; i < 3; i++)  cyc(1'b0, 4'b0100);
        for (int i = 0; i < 12; i++) cyc(1'b0, 4'b0000);
        chk("bounce_sw", o_sw, 4'b0000);
        chk_int("bounce_pulses", pulses.size(), 0);

        // Bounce to a third value: counter restarts on 1000.
        cyc(1'b1, 4'b0000);
        pulses.delete();
        for (int i = 0; i < 2; i++) cyc(1'b0, 4'b0001);
        for (int i = 0; i < 6; i++) cyc(1'b0, 4'b1000);
        chk("third_early_sw", o_sw, 4'b0000);
        cyc(1'b0, 4'b1000);
        chk("third_commit_sw", o_sw, 4'b1000);
        chk("third_commit_chg", {3'b000, o_change}, 4'b0001);
        for (int i = 0; i < 8; i++) cyc(1'b0, 4'b1000);
        chk_int("third_pulses", pulses.size(), 1);

        // Reset in the middle of settling, input held at 1000.
        cyc(1'b1, 4'b0000);
        pulses.delete();
        for (int i = 0; i < 5; i++) cyc(1'b0, 4'b1000);
        cyc(1'b1, 4'b1000);
        chk("rst_mid_sw", o_sw, 4'b0000);
        chk("rst_mid_flags", {1'b0, o_mode_valid, o_error, o_change}, 4'b0000);
        for (int i = 0; i < 6; i++) cyc(1'b0, 4'b1000);
        chk("rst_mid_early_sw", o_sw, 4'b0000);
        cyc(1'b0, 4'b1000);
        chk("rst_mid_commit_sw", o_sw, 4'b1000);
        chk("rst_mid_commit_valid", {3'b000, o_mode_valid}, 4'b0001);
        chk_int("rst_mid_pulses", pulses.size(), 1);

        // Throughput: two commits 10 cycles apart.
        cyc(1'b1, 4'b0000);
        pulses.delete();
        for (int i = 0; i < 10; i++) cyc(1'b0, 4'b0001);
        for (int i = 0; i < 12; i++) cyc(1'b0, 4'b0010);
        chk_int("thru_pulses", pulses.size(), 2);
        if (pulses.size() >= 2) chk_int("thru_spacing", pulses[1] - pulses[0], 10);
        chk("thru_sw", o_sw, 4'b0010);

        // Randomized holds and occasional resets against the model.
        cyc(1'b1, 4'b0000);
        for (int n = 0; n < 600; n++) begin
            logic [3:0] v;
            int hold;
            v    = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 9);
            for (int h = 0; h < hold; h++) begin
                cyc(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, v);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
